dmem_ctrl: RTL and testbench

//  Parametrised data memory for the RV32I datapath, replacing the fixed 64-word combinational-read RAM.

---
 rtl/dmem_ctrl.sv | 108 ++++++++++
 tb/tb_dmem_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: RV32I data memory with byte/half/word lane steering, load extension, configurable read latency
// and a valid/ready request/response handshake. Define DMEM_BOUNDS_CHECK_EN to flag out-of-range addresses.
module dmem_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int READ_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [1:0] CNT_INIT = READ_LAT > 1 ? 2'(READ_LAT - 2) : 2'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [31:0]       mem_q [DEPTH_WORDS];
    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane;
    logic              accept, mis, oob, err, wr;
    logic [31:0]       rword, load_val, wword;
    logic [15:0]       sh;
    logic [3:0]        be;

    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign idx       = req_addr[IDX_W+1:2];
    assign lane      = req_addr[1:0];
    assign mis       = (req_size == 2'b11) || (req_size == 2'b01 && lane[0]) || (req_size == 2'b10 && lane != 2'b00);
`ifdef DMEM_BOUNDS_CHECK_EN
    assign oob = |req_addr[ADDR_W-1:IDX_W+2];
`else
    logic unused_addr;
    assign oob         = 1'b0;
    assign unused_addr = ^req_addr[ADDR_W-1:IDX_W+2];
`endif
    assign err      = mis || oob;
    assign wr       = accept && req_we && !err;
    assign rword    = mem_q[idx];
    assign sh       = 16'(rword >> {lane, 3'b000});
    assign load_val = req_size == 2'b00 ? {{24{!req_unsigned && sh[7]}}, sh[7:0]}
                    : req_size == 2'b01 ? {{16{!req_unsigned && sh[15]}}, sh}
                    : rword;
    assign wword    = req_size == 2'b00 ? {4{req_wdata[7:0]}} : req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    assign be       = req_size == 2'b00 ? 4'b0001 << lane : req_size == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    assign rsp_valid = state_q == RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Store commits on the accepting edge, only addressed lanes; RAM is never reset.
    always_ff @(posedge clk) begin
        if (wr)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem_q[idx][8*i +: 8] <= wword[8*i +: 8];
    end

    // Handshake FSM: capture the extended load (or zero for stores/errors) at accept, then wait out the latency.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = READ_LAT > 1 ? WAIT : RESP;
                cnt_d   = CNT_INIT;
                err_d   = err;
                rdata_d = (req_we || err) ? 32'd0 : load_val;
            end
            WAIT: begin
                state_d = cnt_q == 2'd0 ? RESP : WAIT;
                cnt_d   = cnt_q - 2'd1;
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // State and response registers; reset drops any pending response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized bench for dmem_ctrl, one instance at READ_LAT=1 and one at READ_LAT=3, byte-array reference model
module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, rsp_ready;
    logic [1:0]  req_ready, rsp_valid, rsp_err;
    logic        req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] rsp_rdata [2];
    logic [7:0]  mb [2][256];
    int          lat [2] = '{1, 3};
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(64), .READ_LAT(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .reset(reset),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
            .req_addr(req_addr), .req_wdata(req_wdata),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction on instance d, with the response held off for 'hold' cycles.
    task automatic xact(input int d, input bit we, input logic [1:0] sz, input bit un,
                        input logic [31:0] a, input logic [31:0] wd, input int hold);
        logic [31:0] er, got;
        bit          ee;
        int          n, lt, base;
        n    = 1 << sz;
        base = int'(a & 32'hFF);
        ee   = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`ifdef DMEM_BOUNDS_CHECK_EN
        ee = ee || a >= 32'd256;
`endif
        er = 32'd0;
        if (!ee && we)
            for (int i = 0; i < n; i++) mb[d][base + i] = wd[8*i +: 8];
        if (!ee && !we) begin
            for (int i = 0; i < n; i++) er[8*i +: 8] = mb[d][base + i];
            if (!un && n < 4 && er[8*n-1]) er = er | ~((32'd1 << (8*n)) - 32'd1);
        end
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
        req_valid[d] = 1'b1;
        chk("ready_idle", {31'd0, req_ready[d]}, 32'd1);
        @(posedge clk); #1;
        req_valid[d] = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        lt = 1;
        while (!rsp_valid[d] && lt < 10) begin
            @(posedge clk); #1;
            lt++;
        end
        chk("latency", lt, lat[d]);
        chk("rdata", rsp_rdata[d], er);
        chk("err", {31'd0, rsp_err[d]}, {31'd0, ee});
        got = rsp_rdata[d];
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, rsp_valid[d]}, 32'd1);
            chk("hold_rdata", rsp_rdata[d], got);
            chk("busy_ready", {31'd0, req_ready[d]}, 32'd0);
        end
        rsp_ready[d] = 1'b1; req_valid[d] = 1'b0;
        chk("resp_ready", {31'd0, req_ready[d]}, 32'd0);
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        chk("done_valid", {31'd0, rsp_valid[d]}, 32'd0);
        chk("done_ready", {31'd0, req_ready[d]}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
        req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                chk("rst_ready", {31'd0, req_ready[d]}, 32'd0);
                chk("rst_valid", {31'd0, rsp_valid[d]}, 32'd0);
                chk("rst_err", {31'd0, rsp_err[d]}, 32'd0);
                chk("rst_rdata", rsp_rdata[d], 32'd0);
            end
        end
        reset = 1'b0; #1;
        for (int d = 0; d < 2; d++) chk("post_rst_ready", {31'd0, req_ready[d]}, 32'd1);
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 64; w++) xact(d, 1, 2'd2, 0, 32'(4*w), $urandom, 0);
            xact(d, 1, 2'd2, 0, 32'h10, 32'h8000_00FF, 0);
            xact(d, 0, 2'd0, 0, 32'h10, 0, 0);
            xact(d, 0, 2'd0, 1, 32'h10, 0, 1);
            xact(d, 0, 2'd1, 0, 32'h12, 0, 0);
            xact(d, 0, 2'd2, 0, 32'h10, 0, 2);
            xact(d, 1, 2'd2, 0, 32'h20, 32'h1122_3344, 0);
            xact(d, 1, 2'd0, 0, 32'h21, 32'h0000_00AA, 0);
            xact(d, 0, 2'd2, 0, 32'h20, 0, 0);
            xact(d, 1, 2'd1, 0, 32'h22, 32'h0000_BEEF, 0);
            xact(d, 0, 2'd2, 0, 32'h20, 0, 0);
            xact(d, 0, 2'd1, 0, 32'h13, 0, 0);
            xact(d, 1, 2'd2, 0, 32'h16, 32'hDEAD_BEEF, 0);
            xact(d, 1, 2'd3, 0, 32'h14, 32'hCAFE_F00D, 0);
            xact(d, 0, 2'd2, 0, 32'h14, 0, 0);
            xact(d, 0, 2'd2, 0, 32'h100, 0, 0);
            xact(d, 1, 2'd2, 0, 32'h104, 32'h1234_5678, 0);
            xact(d, 0, 2'd2, 0, 32'h4, 0, 0);
            xact(d, 0, 2'd2, 0, 32'h20, 0, 5);
            for (int k = 0; k < 80; k++) begin
                logic [1:0] sz;
                sz = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
                xact(d, 1'($urandom), sz, 1'($urandom), 32'($urandom_range(0, 1023)), $urandom, $urandom_range(0, 3));
            end
        end
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h5;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        mb[1][0] = 8'h05; mb[1][1] = 8'h00; mb[1][2] = 8'h00; mb[1][3] = 8'h00;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", {31'd0, rsp_valid[1]}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready[1]}, 32'd0);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst_drop", {31'd0, rsp_valid[1]}, 32'd0);
        end
        chk("midrst_idle", {31'd0, req_ready[1]}, 32'd1);
        xact(1, 0, 2'd2, 0, 32'h0, 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
